// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay timer: each channel counts qualified enables after a start
// and raises a one-cycle reached pulse when (delay << DELAY_SHIFT) enables have been seen.
// Latency: start->busy 1 cycle; terminal enable->reached 1 cycle. Always ready, no backpressure.
// Ports: fast_clk_i/fast_rst_n_i (clock, async active-low reset); per-channel start_i, abort_i,
//   mode_i (0 one-shot, 1 periodic), delay_i (WIDTH bits per channel), count_enable_i;
//   outputs reached_o (pulse), busy_o (running), done_o (sticky one-shot completion).
module multi_delay_timer #(
    parameter int NCHAN       = 4,
    parameter int WIDTH       = 16,
    parameter int DELAY_SHIFT = 0
) (
    input  logic                   fast_clk_i,
    input  logic                   fast_rst_n_i,
    input  logic [NCHAN-1:0]       start_i,
    input  logic [NCHAN-1:0]       abort_i,
    input  logic [NCHAN-1:0]       mode_i,
    input  logic [NCHAN*WIDTH-1:0] delay_i,
    input  logic [NCHAN-1:0]       count_enable_i,
    output logic [NCHAN-1:0]       reached_o,
    output logic [NCHAN-1:0]       busy_o,
    output logic [NCHAN-1:0]       done_o
);

    localparam int CW = WIDTH + DELAY_SHIFT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q [NCHAN];
    state_e          state_d [NCHAN];
    logic [CW-1:0]   cnt_q   [NCHAN];
    logic [CW-1:0]   cnt_d   [NCHAN];
    logic [CW-1:0]   term_q  [NCHAN];
    logic [CW-1:0]   term_d  [NCHAN];
    logic [CW-1:0]   start_term [NCHAN];
    logic [NCHAN-1:0] mode_q, mode_d;
    logic [NCHAN-1:0] reached_q, reached_d;
    logic [NCHAN-1:0] busy_q, busy_d;
    logic [NCHAN-1:0] done_q, done_d;

    // Terminal count loaded on start. A periodic channel with a zero delay would never
    // reload sensibly, so it is treated as a period of one enable.
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            start_term[c] = CW'(delay_i[c*WIDTH +: WIDTH]) << DELAY_SHIFT;
            if (mode_i[c] && (start_term[c] == '0)) begin
                start_term[c] = CW'(1);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            term_d[c]    = term_q[c];
            mode_d[c]    = mode_q[c];
            reached_d[c] = 1'b0;

            if (abort_i[c]) begin
                state_d[c] = ST_IDLE;
                cnt_d[c]   = '0;
            end else if (start_i[c]) begin
                state_d[c] = ST_RUN;
                cnt_d[c]   = '0;
                term_d[c]  = start_term[c];
                mode_d[c]  = mode_i[c];
                // One-shot with zero delay: the start is its own terminal event.
                if (!mode_i[c] && (start_term[c] == '0)) begin
                    reached_d[c] = 1'b1;
                end
            end else if (state_q[c] == ST_RUN) begin
                if (!mode_q[c] && (term_q[c] == '0)) begin
                    // Zero-delay one-shot already pulsed on its start; finish after one busy cycle.
                    state_d[c] = ST_DONE;
                end else if (count_enable_i[c]) begin
                    // cnt stays below term, so cnt+1 cannot overflow CW bits.
                    if ((cnt_q[c] + CW'(1)) == term_q[c]) begin
                        reached_d[c] = 1'b1;
                        if (mode_q[c]) begin
                            cnt_d[c] = '0;
                        end else begin
                            state_d[c] = ST_DONE;
                        end
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
            end

            busy_d[c] = (state_d[c] == ST_RUN);
            done_d[c] = (state_d[c] == ST_DONE);
        end
    end

    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
                term_q[c]  <= '0;
            end
            mode_q    <= '0;
            reached_q <= '0;
            busy_q    <= '0;
            done_q    <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                term_q[c]  <= term_d[c];
            end
            mode_q    <= mode_d;
            reached_q <= reached_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign reached_o = reached_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
